// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin sharing of one countdown timer; TMR_ARB_WATCHDOG_EN adds a RUN watchdog
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_val,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done_out,
    output logic                   busy,
    output logic                   tmr_load,
    output logic [WIDTH-1:0]       tmr_val,
    input  logic                   tmr_done,
    output logic                   wdt_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic             blank;

    logic             arb_hit;
    logic [PTR_W-1:0] arb_idx;
    logic [PTR_W-1:0] cand;
    int               cand_i;
    logic [WIDTH-1:0] arb_val;

`ifdef TMR_ARB_WATCHDOG_EN
    logic [WIDTH+1:0] wdt_cnt;
    logic             wdt_err_q;
`endif

    // Scan from the slot after the last winner, wrapping, so the last winner is checked last.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        cand_i  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_i = int'(ptr) + k;
            if (cand_i >= N_REQ) begin
                cand_i = cand_i - N_REQ;
            end
            cand = PTR_W'(cand_i);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
        arb_val = req_val[int'(arb_idx)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            done_out <= '0;
            busy     <= 1'b0;
            tmr_load <= 1'b0;
            tmr_val  <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            gidx     <= '0;
            blank    <= 1'b0;
`ifdef TMR_ARB_WATCHDOG_EN
            wdt_cnt   <= '0;
            wdt_err_q <= 1'b0;
`endif
        end else begin
            tmr_load <= 1'b0;
            done_out <= '0;
`ifdef TMR_ARB_WATCHDOG_EN
            wdt_err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // A live done_out marks the closing cycle of the previous op: hold off one cycle.
                    if (arb_hit && (done_out == '0)) begin
                        state   <= S_LOAD;
                        grant   <= N_REQ'(1) << arb_idx;
                        gidx    <= arb_idx;
                        tmr_val <= arb_val;
                        busy    <= 1'b1;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    tmr_load <= 1'b1;
                    blank    <= 1'b1;
`ifdef TMR_ARB_WATCHDOG_EN
                    wdt_cnt  <= '0;
`endif
                    state    <= (tmr_val == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    // The timer still shows the previous op's flag until our load lands.
                    blank <= 1'b0;
                    if (!blank && tmr_done) begin
                        state <= S_DONE;
                    end
`ifdef TMR_ARB_WATCHDOG_EN
                    else if (wdt_cnt == '1) begin
                        wdt_err_q <= 1'b1;
                        done_out  <= grant;
                        ptr       <= gidx;
                        state     <= S_IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    done_out <= grant;
                    ptr      <= gidx;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TMR_ARB_WATCHDOG_EN
    assign wdt_err = wdt_err_q;
`else
    assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - directed vector bench for timer_arbiter
module tb_timer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_val;
    logic [3:0]  grant;
    logic [3:0]  done_out;
    logic        busy;
    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tmr_done;
    logic        wdt_err;

    logic [7:0]  tm_cnt;
    logic        tm_done;
    logic        ovr;
    logic        ovr_val;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] vals;
        logic [3:0]  g;
        logic [7:0]  v;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    timer_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req      (req),
        .req_val  (req_val),
        .grant    (grant),
        .done_out (done_out),
        .busy     (busy),
        .tmr_load (tmr_load),
        .tmr_val  (tmr_val),
        .tmr_done (tmr_done),
        .wdt_err  (wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Countdown timer: flag rises val cycles after the load is taken and holds until the next load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_cnt  <= 8'd0;
            tm_done <= 1'b0;
        end else if (tmr_load) begin
            tm_cnt  <= tmr_val;
            tm_done <= (tmr_val == 8'd0);
        end else if (tm_cnt != 8'd0) begin
            tm_cnt  <= tm_cnt - 8'd1;
            tm_done <= (tm_cnt == 8'd1);
        end
    end

    assign tmr_done = ovr ? ovr_val : tm_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            if (grant != 4'd0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL grant_timeout: got grant=%0h expected nonzero", grant);
        end
    endtask

    task automatic run_vec(input vec_t vv, input int idx);
        bit ok;
        int lat;
        req     = vv.req;
        req_val = vv.vals;
        wait_grant(ok);
        if (!ok) return;
        check($sformatf("v%0d_grant", idx), grant, vv.g);
        check($sformatf("v%0d_tmr_val", idx), tmr_val, vv.v);
        check($sformatf("v%0d_busy", idx), busy, 1);
        check($sformatf("v%0d_load_early", idx), tmr_load, 0);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 400) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check($sformatf("v%0d_load_pulse", idx), tmr_load, 1);
            if (lat == 2) check($sformatf("v%0d_load_end", idx), tmr_load, 0);
            if (done_out != 4'd0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL v%0d_done_timeout: got no done_out expected %0h", idx, vv.g);
            return;
        end
        check($sformatf("v%0d_done_out", idx), done_out, vv.g);
        check($sformatf("v%0d_latency", idx), lat, vv.lat);
        check($sformatf("v%0d_grant_at_done", idx), grant, vv.g);
        check($sformatf("v%0d_tmr_val_held", idx), tmr_val, vv.v);
        @(negedge clk);
        check($sformatf("v%0d_done_cleared", idx), done_out, 0);
        check($sformatf("v%0d_grant_dropped", idx), grant, 0);
        check($sformatf("v%0d_busy_dropped", idx), busy, 0);
    endtask

    initial begin
        bit   ok;
        int   lat;
        int   wseen;
        vec_t vx;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'd0;
        req_val  = 32'd0;
        ovr      = 1'b0;
        ovr_val  = 1'b0;

        // req, vals {v3,v2,v1,v0}, expected grant, expected tmr_val, grant-to-done_out cycles
        vecs[0] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     4'b0001, 8'd1,   5};
        vecs[1] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     4'b0010, 8'd2,   6};
        vecs[2] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     4'b0100, 8'd3,   7};
        vecs[3] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     4'b1000, 8'd4,   8};
        vecs[4] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     4'b0001, 8'd1,   5};
        vecs[5] = '{4'b0001, {8'd4, 8'd3, 8'd2, 8'd3},     4'b0001, 8'd3,   7};
        vecs[6] = '{4'b0100, {8'd4, 8'd0, 8'd2, 8'd3},     4'b0100, 8'd0,   2};
        vecs[7] = '{4'b1010, {8'd9, 8'd8, 8'd7, 8'd6},     4'b1000, 8'd9,   13};
        vecs[8] = '{4'b1010, {8'd9, 8'd8, 8'd7, 8'd6},     4'b0010, 8'd7,   11};
        vecs[9] = '{4'b0011, {8'd1, 8'd1, 8'd5, 8'd255},   4'b0001, 8'd255, 259};

        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done_out", done_out, 0);
        check("rst_busy", busy, 0);
        check("rst_tmr_load", tmr_load, 0);
        check("rst_tmr_val", tmr_val, 0);
        check("rst_wdt_err", wdt_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", grant, 0);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Stale done flag across the blanking cycle, value change and request drop mid-op.
        ovr     = 1'b1;
        ovr_val = 1'b1;
        req     = 4'b0010;
        req_val = {8'd9, 8'd8, 8'd5, 8'd1};
        wait_grant(ok);
        if (ok) begin
            check("stale_grant", grant, 4'b0010);
            check("stale_tmr_val", tmr_val, 5);
            req_val = {8'd9, 8'd8, 8'd77, 8'd1};
            req     = 4'b0000;
            lat     = 0;
            ok      = 1'b0;
            while (!ok && lat < 20) begin
                @(negedge clk);
                lat++;
                if (done_out != 4'd0) ok = 1'b1;
            end
            check("stale_latency", lat, 4);
            check("stale_done_out", done_out, 4'b0010);
            check("stale_tmr_val_kept", tmr_val, 5);
            @(negedge clk);
            check("stale_single_pulse", done_out, 0);
            check("stale_grant_dropped", grant, 0);
        end
        ovr = 1'b0;

        // Timer never finishes.
        ovr     = 1'b1;
        ovr_val = 1'b0;
        req     = 4'b0001;
        req_val = {8'd1, 8'd1, 8'd1, 8'd10};
        wait_grant(ok);
        check("stuck_grant", grant, 4'b0001);
`ifdef TMR_ARB_WATCHDOG_EN
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 1200) begin
            @(negedge clk);
            lat++;
            if (wdt_err) ok = 1'b1;
        end
        check("wdt_latency", lat, 1025);
        check("wdt_done_out", done_out, 4'b0001);
        @(negedge clk);
        check("wdt_err_pulse", wdt_err, 0);
        check("wdt_done_cleared", done_out, 0);
        check("wdt_grant_dropped", grant, 0);
        wait_grant(ok);
        check("wdt_regrant", grant, 4'b0001);
        repeat (5) @(negedge clk);
`else
        wseen = 0;
        repeat (1100) begin
            @(negedge clk);
            if (wdt_err || done_out != 4'd0) wseen++;
        end
        check("nowdt_busy", busy, 1);
        check("nowdt_grant", grant, 4'b0001);
        check("nowdt_no_pulse", wseen, 0);
`endif

        // Asynchronous reset in the middle of RUN.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tmr_load", tmr_load, 0);
        check("midrst_done_out", done_out, 0);
        check("midrst_tmr_val", tmr_val, 0);
        req = 4'b0000;
        ovr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("midrst_idle_grant", grant, 0);
            check("midrst_idle_busy", busy, 0);
        end

        // Pointer is back at N_REQ-1, so slot 0 wins over slot 3.
        vx = '{4'b1001, {8'd6, 8'd1, 8'd1, 8'd2}, 4'b0001, 8'd2, 6};
        run_vec(vx, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
